ddr_wr_seq: RTL and testbench
=============================

DDR_WR_SEQ -- requirements
Module: ddr_wr_seq

Interface
REQ-001 SHALL have ports: pclk  in  1  slow (pclk) clock; the only clock.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: cfg_cwl  in  3  write latency in pclk cycles; legal range 2..5.
REQ-004 SHALL have ports: wr_valid  in  1  write burst offered; wr_ready  out  1  burst accepted when both high at a pclk edge.
REQ-005 SHALL have ports: wr_data  in  64  8 lanes x 8 beats; wr_mask  in  8  per-beat data mask.
REQ-006 SHALL have ports: dq_word  out  64  lane i on bits [8i+7:8i], beat j on bit j; dm_word  out  8; dqs_word  out  8.
REQ-007 SHALL have ports: dq_oe  out  1; dqs_oe  out  1; busy  out  1  any burst in flight or on the pins.

Function
REQ-008 SHALL register all outputs except wr_ready and busy.
REQ-009 SHALL use cwl_q, a copy of cfg_cwl taken on every edge where busy=0; it is clamped to 2 if below 2 and to 5 if above 5.
REQ-010 SHALL hold accepted bursts in an 8-entry FIFO; wr_ready = not FIFO full.
REQ-011 SHALL enter a 1 into a tag delay line for each accepted burst; the tag reaches the output at stage cwl_q.
REQ-012 SHALL drive a burst accepted at edge T during cycle T+cwl_q: dq_word=wr_data, dm_word=wr_mask, dq_oe=1, dqs_oe=1, dqs_word=8'h55. The FIFO pops at that edge.
REQ-013 SHALL drive the preamble during cycle T+cwl_q-1 when no burst occupies that cycle: dqs_oe=1, dqs_word=8'h00, dq_oe=0.
REQ-014 SHALL drive the postamble in the cycle after the last burst when no burst occupies that cycle: dqs_oe=1, dqs_word=8'h00, dq_oe=0.
REQ-015 SHALL stream bursts accepted on consecutive edges on consecutive cycles, with no preamble or postamble between them.
REQ-016 SHALL drive a single merged cycle when the postamble of one burst and the preamble of the next coincide (one-cycle gap): dqs_oe=1, dqs_word=8'h00.
REQ-017 SHALL drive dq_word=0, dm_word=0, dqs_word=0, dq_oe=0 and dqs_oe=0 when idle.
REQ-018 SHALL sequence with state machine IDLE -> WAIT (tags pending, pins idle) -> PRE -> DATA -> POST -> IDLE|WAIT|PRE. DATA->DATA holds while the next tag is due; POST merges with PRE per REQ-016.
REQ-019 SHALL assert busy while the FIFO is non-empty, any tag is set, or the state is not IDLE.
REQ-020 SHALL never pop an empty FIFO; a due tag with an empty FIFO is a design error, flagged by an assertion.

Reset
REQ-021 SHALL, on rst_n low at any time including mid-burst, immediately clear the FIFO, tags and state to IDLE, and force all outputs to 0, with wr_ready=1 and cwl_q=2.
REQ-022 SHALL resume acceptance on the first edge after rst_n deasserts.

Structure
REQ-023 SHALL take LANES=8, BEATS=8, CWL_MIN=2, CWL_MAX=5, DQS_TOGGLE=8'h55, DQS_IDLE=8'h00 and the state enum from shared package ddr_phy_pkg.
REQ-024 SHALL instantiate one sub-module, ddr_wr_fifo: synchronous, 8 deep, 72 bits wide (data+mask), with full/empty flags and async active-low reset.
REQ-025 SHALL connect its outputs directly to the serializer lanes; fclk-domain logic is out of scope.

Verification
REQ-026 SHALL cover: cwl=3, single burst data=64'h0123456789ABCDEF accepted at T -> PRE at T+2, DATA at T+3 with dqs_word=55 and dq_oe=1, POST at T+4, idle at T+5.
REQ-027 SHALL cover: cwl=2, 4 bursts on consecutive edges -> one PRE, 4 contiguous DATA cycles in order, one POST, busy low afterwards.
REQ-028 SHALL cover: cwl=4, two bursts 2 edges apart -> DATA, merged 00 cycle with dq_oe=0, DATA, POST.
REQ-029 SHALL cover: cfg_cwl=7 then cfg_cwl=0 -> behaves as 5 and 2 respectively; cfg_cwl changed while busy -> takes no effect until idle.
REQ-030 SHALL cover: rst_n pulled low during the second of 3 streamed bursts -> all outputs 0 within the same cycle; after release, a new burst follows the REQ-026 timing.
REQ-031 SHALL cover: cwl=5, 8 consecutive bursts -> wr_ready never deasserts, FIFO never overflows, and all 8 appear in order.

Source files
------------

// File: rtl/ddr_phy_pkg.sv
// Shared constants, FSM state type and CWL clamp helper for the DDR write path.
package ddr_phy_pkg;
  localparam int LANES      = 8;
  localparam int BEATS      = 8;
  localparam int BURST_W    = LANES * BEATS;
  localparam int CWL_MIN    = 2;
  localparam int CWL_MAX    = 5;
  localparam int FIFO_DEPTH = 8;
  localparam logic [BEATS-1:0] DQS_TOGGLE = 8'h55;
  localparam logic [BEATS-1:0] DQS_IDLE   = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PRE,
    ST_DATA,
    ST_POST
  } wr_state_e;

  function automatic logic [2:0] clamp_cwl(input logic [2:0] cwl);
    if (cwl < 3'(CWL_MIN)) return 3'(CWL_MIN);
    if (cwl > 3'(CWL_MAX)) return 3'(CWL_MAX);
    return cwl;
  endfunction
endpackage

// File: rtl/ddr_wr_fifo.sv
// Show-ahead synchronous FIFO holding accepted write bursts (data + mask).
module ddr_wr_fifo
  import ddr_phy_pkg::*;
#(
  parameter int W     = 72,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/ddr_wr_seq.sv
// DDR write sequencer: queues bursts, delays them by CWL and frames them with
// DQS preamble/postamble. Handshake: a burst transfers on any pclk edge where
// wr_valid and wr_ready are both high; wr_valid may be raised independently.
module ddr_wr_seq
  import ddr_phy_pkg::*;
(
  input  logic               pclk,
  input  logic               rst_n,
  input  logic [2:0]         cfg_cwl,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [BURST_W-1:0] wr_data,
  input  logic [BEATS-1:0]   wr_mask,
  output logic [BURST_W-1:0] dq_word,
  output logic [BEATS-1:0]   dm_word,
  output logic [BEATS-1:0]   dqs_word,
  output logic               dq_oe,
  output logic               dqs_oe,
  output logic               busy,
  output wr_state_e          dbg_state
);
  wr_state_e                  state_q;
  logic [2:0]                 cwl_q;
  logic [7:0]                 tags_q, tags_d;
  logic [BURST_W-1:0]         dq_q;
  logic [BEATS-1:0]           dm_q, dqs_q;
  logic                       dq_oe_q, dqs_oe_q;
  logic                       accept, due, pre_due;
  logic                       fifo_full, fifo_empty;
  logic [BURST_W+BEATS-1:0]   fifo_rdata;

  assign wr_ready = !fifo_full;
  assign accept   = wr_valid && !fifo_full;
  // Bit k of the tag line is stage k+1; stage cwl_q is due on the pins now.
  assign due      = tags_q[cwl_q - 3'd1];
  assign pre_due  = tags_q[cwl_q - 3'd2];
  assign busy     = !fifo_empty || (|tags_q) || (state_q != ST_IDLE);

  always_comb begin
    tags_d    = '0;
    tags_d[0] = accept;
    for (int k = 1; k < 8; k++) begin
      if (3'(k) < cwl_q) tags_d[k] = tags_q[k-1];
    end
  end

  ddr_wr_fifo #(.W(BURST_W + BEATS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (pclk),
    .rst_ni  (rst_n),
    .push_i  (accept),
    .pop_i   (due && !fifo_empty),
    .wdata_i ({wr_mask, wr_data}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tags_q   <= '0;
      cwl_q    <= 3'(CWL_MIN);
      dq_q     <= '0;
      dm_q     <= '0;
      dqs_q    <= DQS_IDLE;
      dq_oe_q  <= 1'b0;
      dqs_oe_q <= 1'b0;
    end else begin
      tags_q <= tags_d;
      if (!busy) cwl_q <= clamp_cwl(cfg_cwl);
      if (due) begin
        state_q  <= ST_DATA;
        dq_q     <= fifo_rdata[BURST_W-1:0];
        dm_q     <= fifo_rdata[BURST_W+BEATS-1:BURST_W];
        dqs_q    <= DQS_TOGGLE;
        dq_oe_q  <= 1'b1;
        dqs_oe_q <= 1'b1;
      end else if (pre_due || state_q == ST_DATA) begin
        // Postamble and preamble share one quiet DQS cycle when they coincide.
        state_q  <= pre_due ? ST_PRE : ST_POST;
        dq_q     <= '0;
        dm_q     <= '0;
        dqs_q    <= DQS_IDLE;
        dq_oe_q  <= 1'b0;
        dqs_oe_q <= 1'b1;
      end else begin
        state_q  <= (|tags_d) ? ST_WAIT : ST_IDLE;
        dq_q     <= '0;
        dm_q     <= '0;
        dqs_q    <= DQS_IDLE;
        dq_oe_q  <= 1'b0;
        dqs_oe_q <= 1'b0;
      end
    end
  end

  assign dq_word   = dq_q;
  assign dm_word   = dm_q;
  assign dqs_word  = dqs_q;
  assign dq_oe     = dq_oe_q;
  assign dqs_oe    = dqs_oe_q;
  assign dbg_state = state_q;

  a_no_pop_empty: assert property (@(posedge pclk) disable iff (!rst_n) !(due && fifo_empty));
endmodule

// File: tb/tb_ddr_wr_seq.sv
// Bench for ddr_wr_seq: burst-list model of pin timing, per-cycle compare,
// plus literal timing checks for the directed scenarios.
module tb_ddr_wr_seq;
  import ddr_phy_pkg::*;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  cfg_cwl = 3'd3;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [63:0] wr_data = '0;
  logic [7:0]  wr_mask = '0;
  logic [63:0] dq_word;
  logic [7:0]  dm_word, dqs_word;
  logic        dq_oe, dqs_oe, busy;
  wr_state_e   dbg_state;

  always #5 pclk = ~pclk;

  ddr_wr_seq dut (
    .pclk(pclk), .rst_n(rst_n), .cfg_cwl(cfg_cwl), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .wr_mask(wr_mask),
    .dq_word(dq_word), .dm_word(dm_word), .dqs_word(dqs_word),
    .dq_oe(dq_oe), .dqs_oe(dqs_oe), .busy(busy), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: every accepted burst is (accept edge n, data cycle d = n + cwl).
  int          b_n [64];
  int          b_d [64];
  logic [63:0] b_data [64];
  logic [7:0]  b_mask [64];
  int          nb = 0;
  int          cwl_m = 2;

  logic [63:0] log_dq [2048];
  logic [7:0]  log_dm [2048], log_dqs [2048];
  logic        log_dq_oe [2048], log_dqs_oe [2048], log_busy [2048], log_ready [2048];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int clamp(input int c);
    return (c < 2) ? 2 : ((c > 5) ? 5 : c);
  endfunction

  // Busy from the first edge of a burst through its postamble cycle.
  function automatic bit m_busy(input int k);
    for (int i = 0; i < nb; i++) if (b_n[i] <= k && k <= b_d[i] + 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_occ(input int k);
    int c = 0;
    for (int i = 0; i < nb; i++) if (b_n[i] <= k && b_d[i] > k) c++;
    return c;
  endfunction

  always @(posedge pclk) begin
    cyc = cyc + 1;
    if (!rst_n) nb = 0;
    else begin
      if (!m_busy(cyc - 1)) cwl_m = clamp(int'(cfg_cwl));
      if (wr_valid && m_occ(cyc - 1) < 8) begin
        b_n[nb] = cyc; b_d[nb] = cyc + cwl_m; b_data[nb] = wr_data; b_mask[nb] = wr_mask;
        nb = nb + 1;
      end
    end
  end

  always @(negedge rst_n) nb = 0;

  always @(negedge pclk) begin
    logic [63:0] e_dq;
    logic [7:0]  e_dm, e_dqs;
    logic        e_dq_oe, e_dqs_oe, framed;
    e_dq = '0; e_dm = '0; e_dqs = '0; e_dq_oe = 1'b0; e_dqs_oe = 1'b0; framed = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (b_d[i] == cyc) begin
        e_dq = b_data[i]; e_dm = b_mask[i]; e_dqs = 8'h55; e_dq_oe = 1'b1; e_dqs_oe = 1'b1;
      end
      if (b_d[i] == cyc + 1 || b_d[i] == cyc - 1) framed = 1'b1;
    end
    if (!e_dq_oe && framed) e_dqs_oe = 1'b1;
    chk("m_dq_word", dq_word, e_dq);
    chk("m_dm_word", 64'(dm_word), 64'(e_dm));
    chk("m_dqs_word", 64'(dqs_word), 64'(e_dqs));
    chk("m_dq_oe", 64'(dq_oe), 64'(e_dq_oe));
    chk("m_dqs_oe", 64'(dqs_oe), 64'(e_dqs_oe));
    chk("m_wr_ready", 64'(wr_ready), 64'(m_occ(cyc) < 8));
    chk("m_busy", 64'(busy), 64'(m_busy(cyc)));
    if (cyc < 2048) begin
      log_dq[cyc] = dq_word; log_dm[cyc] = dm_word; log_dqs[cyc] = dqs_word;
      log_dq_oe[cyc] = dq_oe; log_dqs_oe[cyc] = dqs_oe;
      log_busy[cyc] = busy; log_ready[cyc] = wr_ready;
    end
  end

  task automatic send(input logic [63:0] d, input logic [7:0] m, input logic [2:0] c);
    @(negedge pclk);
    wr_valid = 1'b1; wr_data = d; wr_mask = m; cfg_cwl = c;
  endtask

  task automatic gap();
    @(negedge pclk);
    wr_valid = 1'b0; wr_data = '0; wr_mask = '0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy !== 1'b0 && w < 80) begin
      @(negedge pclk);
      w++;
    end
    chk("wait_idle", 64'(busy), 64'(0));
    repeat (2) @(negedge pclk);
  endtask

  task automatic lit(input string name, input int k, input logic [63:0] dq,
                     input logic qoe, input logic soe, input logic [7:0] dqs);
    chk({name, "_dq"}, log_dq[k], dq);
    chk({name, "_dq_oe"}, 64'(log_dq_oe[k]), 64'(qoe));
    chk({name, "_dqs_oe"}, 64'(log_dqs_oe[k]), 64'(soe));
    chk({name, "_dqs"}, 64'(log_dqs[k]), 64'(dqs));
  endtask

  logic [63:0] pats [8] = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                            64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000,
                            64'hCAFE_F00D_0000_0001, 64'hDEAD_BEEF_0000_0002,
                            64'h0BAD_C0DE_0000_0003, 64'hFEED_FACE_0000_0004};

  initial begin
    int t;
    repeat (3) @(negedge pclk);
    chk("rst_dq", dq_word, 64'h0);
    chk("rst_dqs_oe", 64'(dqs_oe), 64'(0));
    chk("rst_ready", 64'(wr_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;

    // cwl=3 single burst
    send(64'h0123456789ABCDEF, 8'hA5, 3'd3); t = cyc + 1; gap(); wait_idle();
    lit("t1_wait", t + 1, 64'h0, 0, 0, 8'h00);
    lit("t1_pre", t + 2, 64'h0, 0, 1, 8'h00);
    lit("t1_data", t + 3, 64'h0123456789ABCDEF, 1, 1, 8'h55);
    chk("t1_dm", 64'(log_dm[t + 3]), 64'hA5);
    lit("t1_post", t + 4, 64'h0, 0, 1, 8'h00);
    lit("t1_idle", t + 5, 64'h0, 0, 0, 8'h00);
    chk("t1_busy_idle", 64'(log_busy[t + 5]), 64'(0));

    // cwl=2, four streamed bursts
    for (int i = 0; i < 4; i++) begin
      send(pats[i], 8'(i), 3'd2);
      if (i == 0) t = cyc + 1;
    end
    gap(); wait_idle();
    lit("t2_pre", t + 1, 64'h0, 0, 1, 8'h00);
    for (int i = 0; i < 4; i++) lit($sformatf("t2_data%0d", i), t + 2 + i, pats[i], 1, 1, 8'h55);
    lit("t2_post", t + 6, 64'h0, 0, 1, 8'h00);
    chk("t2_busy_after", 64'(log_busy[t + 7]), 64'(0));

    // cwl=4, two bursts two edges apart: merged quiet cycle between them
    send(pats[4], 8'h01, 3'd4); t = cyc + 1; gap(); send(pats[5], 8'h02, 3'd4); gap(); wait_idle();
    lit("t3_pre", t + 3, 64'h0, 0, 1, 8'h00);
    lit("t3_data0", t + 4, pats[4], 1, 1, 8'h55);
    lit("t3_merge", t + 5, 64'h0, 0, 1, 8'h00);
    lit("t3_data1", t + 6, pats[5], 1, 1, 8'h55);
    lit("t3_post", t + 7, 64'h0, 0, 1, 8'h00);
    lit("t3_idle", t + 8, 64'h0, 0, 0, 8'h00);

    // cfg_cwl=7 clamps to 5, cfg_cwl=0 clamps to 2
    send(pats[6], 8'h00, 3'd7); t = cyc + 1; gap(); wait_idle();
    lit("t4a_pre", t + 4, 64'h0, 0, 1, 8'h00);
    lit("t4a_data", t + 5, pats[6], 1, 1, 8'h55);
    lit("t4a_post", t + 6, 64'h0, 0, 1, 8'h00);
    send(pats[7], 8'h00, 3'd0); t = cyc + 1; gap(); wait_idle();
    lit("t4b_pre", t + 1, 64'h0, 0, 1, 8'h00);
    lit("t4b_data", t + 2, pats[7], 1, 1, 8'h55);
    lit("t4b_post", t + 3, 64'h0, 0, 1, 8'h00);

    // cfg_cwl changed while busy is ignored until idle
    send(pats[0], 8'h10, 3'd3); t = cyc + 1; send(pats[1], 8'h20, 3'd5); gap(); wait_idle();
    lit("t4c_data0", t + 3, pats[0], 1, 1, 8'h55);
    lit("t4c_data1", t + 4, pats[1], 1, 1, 8'h55);
    lit("t4c_post", t + 5, 64'h0, 0, 1, 8'h00);
    lit("t4c_idle", t + 6, 64'h0, 0, 0, 8'h00);
    send(pats[2], 8'h30, 3'd5); t = cyc + 1; gap(); wait_idle();
    lit("t4d_pre", t + 4, 64'h0, 0, 1, 8'h00);
    lit("t4d_data", t + 5, pats[2], 1, 1, 8'h55);

    // reset during the second of three streamed bursts
    send(pats[3], 8'h01, 3'd3); t = cyc + 1; send(pats[4], 8'h02, 3'd3); send(pats[5], 8'h03, 3'd3); gap();
    while (cyc < t + 4) begin
      @(posedge pclk);
      #1;
    end
    chk("t5_mid_burst", dq_word, pats[4]);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_dq", dq_word, 64'h0);
    chk("t5_rst_dm", 64'(dm_word), 64'h0);
    chk("t5_rst_dqs", 64'(dqs_word), 64'h0);
    chk("t5_rst_dq_oe", 64'(dq_oe), 64'(0));
    chk("t5_rst_dqs_oe", 64'(dqs_oe), 64'(0));
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_ready", 64'(wr_ready), 64'(1));
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    send(64'h0123456789ABCDEF, 8'h5A, 3'd3); t = cyc + 1; gap(); wait_idle();
    lit("t5_pre", t + 2, 64'h0, 0, 1, 8'h00);
    lit("t5_data", t + 3, 64'h0123456789ABCDEF, 1, 1, 8'h55);
    lit("t5_post", t + 4, 64'h0, 0, 1, 8'h00);
    lit("t5_idle", t + 5, 64'h0, 0, 0, 8'h00);

    // cwl=5, eight streamed bursts never stall
    for (int i = 0; i < 8; i++) begin
      send(pats[i], 8'(8'h80 >> i), 3'd5);
      if (i == 0) t = cyc + 1;
    end
    gap(); wait_idle();
    lit("t6_pre", t + 4, 64'h0, 0, 1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t6_ready%0d", i), 64'(log_ready[t + i]), 64'(1));
      lit($sformatf("t6_data%0d", i), t + 5 + i, pats[i], 1, 1, 8'h55);
    end
    lit("t6_post", t + 13, 64'h0, 0, 1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
